// File: rtl/axi_data_check.sv
// Purpose : stream sink that checks generator frames for incrementing data, keep mask and length.
// Latency : o_done pulses exactly one cycle after the final accepted beat.
// Backpres: registered o_ready, low outside RUN, optionally throttled by an 8-bit LFSR in RUN.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   i_start, i_length        arm one frame of i_length bytes (ignored when length is 0 or not idle)
//   i_bp_en                  1 = throttle o_ready with the LFSR, 0 = ready held high in RUN
//   i_data/i_valid/i_keep/i_last, o_ready   checked input stream
//   o_busy, o_done, o_pass   frame status; o_pass valid with o_done and held until next start
//   o_err_data/keep/len      sticky error flags for the current frame
//   o_frame_cnt, o_fail_cnt  saturating completed / failed frame counters
module axi_data_check #(
  parameter int          DATA_WIDTH = 32,
  parameter int          STRB_WIDTH = DATA_WIDTH / 8,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  input  logic [9:0]             i_length,
  input  logic                   i_bp_en,
  input  logic [DATA_WIDTH-1:0]  i_data,
  input  logic                   i_valid,
  input  logic [STRB_WIDTH-1:0]  i_keep,
  input  logic                   i_last,
  output logic                   o_ready,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_pass,
  output logic                   o_err_data,
  output logic                   o_err_keep,
  output logic                   o_err_len,
  output logic [15:0]            o_frame_cnt,
  output logic [15:0]            o_fail_cnt
);

  localparam int LSB = $clog2(STRB_WIDTH);
  localparam int WW  = 10 - LSB + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 r_state;
  logic [WW-1:0]          r_words;
  logic [STRB_WIDTH-1:0]  r_last_keep;
  logic [9:0]             r_beat;
  logic [DATA_WIDTH-1:0]  r_exp;
  logic [7:0]             r_lfsr;
  logic                   r_ready;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_pass;
  logic                   r_err_data;
  logic                   r_err_keep;
  logic                   r_err_len;
  logic [15:0]            r_frame_cnt;
  logic [15:0]            r_fail_cnt;

  logic [LSB-1:0]         w_len_mod;
  logic [WW-1:0]          w_words;
  logic [STRB_WIDTH-1:0]  w_last_keep;
  logic [7:0]             w_lfsr_nxt;
  logic                   w_accept;
  logic                   w_is_final;
  logic [STRB_WIDTH-1:0]  w_exp_keep;
  logic                   w_data_bad;
  logic                   w_keep_bad;
  logic                   w_len_bad;
  logic                   w_end;
  logic                   w_pass_now;

  // Frame geometry derived from the byte length at start time.
  assign w_len_mod = i_length[LSB-1:0];
  assign w_words   = WW'(i_length[9:LSB]) + WW'(|w_len_mod);

  always_comb begin
    w_last_keep = '0;
    for (int k = 0; k < STRB_WIDTH; k++) begin
      w_last_keep[k] = (w_len_mod == '0) || (k < int'(w_len_mod));
    end
  end

  // Fibonacci LFSR, taps 8,6,5,4.
  assign w_lfsr_nxt = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};

  assign w_accept   = (r_state == RUN) && i_valid && r_ready;
  assign w_is_final = (10'(r_words) == (r_beat + 10'd1));
  assign w_exp_keep = w_is_final ? r_last_keep : {STRB_WIDTH{1'b1}};
  assign w_data_bad = (i_data != r_exp);
  assign w_keep_bad = (i_keep != w_exp_keep);
  // Early last and missing last both reduce to "last disagrees with the counted position".
  assign w_len_bad  = (i_last != w_is_final);
  assign w_end      = w_is_final || i_last;
  // Includes errors flagged on the closing beat, which are not yet in the sticky registers.
  assign w_pass_now = ~(r_err_data | w_data_bad | r_err_keep | w_keep_bad | r_err_len | w_len_bad);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_words     <= '0;
      r_last_keep <= '0;
      r_beat      <= '0;
      r_exp       <= '0;
      r_lfsr      <= LFSR_SEED;
      r_ready     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err_data  <= 1'b0;
      r_err_keep  <= 1'b0;
      r_err_len   <= 1'b0;
      r_frame_cnt <= '0;
      r_fail_cnt  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start && (i_length != 10'd0)) begin
            r_state     <= RUN;
            r_words     <= w_words;
            r_last_keep <= w_last_keep;
            r_beat      <= '0;
            r_err_data  <= 1'b0;
            r_err_keep  <= 1'b0;
            r_err_len   <= 1'b0;
            r_pass      <= 1'b0;
            r_busy      <= 1'b1;
            // Ready in RUN always mirrors bit 0 of the LFSR value held in that cycle.
            r_ready     <= i_bp_en ? r_lfsr[0] : 1'b1;
          end
        end
        RUN: begin
          r_lfsr  <= w_lfsr_nxt;
          r_ready <= i_bp_en ? w_lfsr_nxt[0] : 1'b1;
          if (w_accept) begin
            // Resync on the received value so one bad word does not cascade into the next frame.
            r_exp  <= i_data + DATA_WIDTH'(1);
            r_beat <= r_beat + 10'd1;
            if (w_data_bad) r_err_data <= 1'b1;
            if (w_keep_bad) r_err_keep <= 1'b1;
            if (w_end) begin
              if (w_len_bad) r_err_len <= 1'b1;
              r_state <= DONE;
              r_ready <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= w_pass_now;
              if (r_frame_cnt != 16'hFFFF) r_frame_cnt <= r_frame_cnt + 16'd1;
              if (!w_pass_now && (r_fail_cnt != 16'hFFFF)) r_fail_cnt <= r_fail_cnt + 16'd1;
            end
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_ready     = r_ready;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_pass      = r_pass;
  assign o_err_data  = r_err_data;
  assign o_err_keep  = r_err_keep;
  assign o_err_len   = r_err_len;
  assign o_frame_cnt = r_frame_cnt;
  assign o_fail_cnt  = r_fail_cnt;

endmodule

// File: tb/tb_axi_data_check.sv
module tb_axi_data_check;

  localparam int DW = 32;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_start = 1'b0;
  logic [9:0]    i_length = '0;
  logic          i_bp_en = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic          i_valid = 1'b0;
  logic [SW-1:0] i_keep = '0;
  logic          i_last = 1'b0;
  logic          o_ready, o_busy, o_done, o_pass;
  logic          o_err_data, o_err_keep, o_err_len;
  logic [15:0]   o_frame_cnt, o_fail_cnt;

  always #5 clk = ~clk;

  axi_data_check #(.DATA_WIDTH(DW), .STRB_WIDTH(SW), .LFSR_SEED(8'hA5)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_length(i_length), .i_bp_en(i_bp_en),
    .i_data(i_data), .i_valid(i_valid), .i_keep(i_keep), .i_last(i_last),
    .o_ready(o_ready), .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass),
    .o_err_data(o_err_data), .o_err_keep(o_err_keep), .o_err_len(o_err_len),
    .o_frame_cnt(o_frame_cnt), .o_fail_cnt(o_fail_cnt)
  );

  int          n_vec = 0;
  int          n_err = 0;
  bit          cmp_en = 1'b0;
  logic [31:0] gen_cnt = '0;

  // Behavioural model: a frame is "armed" until its closing beat, then reports for one cycle.
  bit          m_armed = 0, m_report = 0, m_ready = 0, m_pass = 0;
  bit          m_ed = 0, m_ek = 0, m_el = 0;
  logic [15:0] m_fc = 0, m_fail = 0;
  logic [31:0] m_exp = 0;
  logic [7:0]  m_lfsr = 8'hA5;
  int          m_words = 0, m_seen = 0;
  logic [3:0]  m_lastkeep = 0;

  function automatic logic [7:0] lfsr_step(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

  function automatic logic [3:0] keep_for_len(input int len);
    if (len % SW == 0) return 4'hF;
    return 4'((1 << (len % SW)) - 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    bit acc, fin, ended;
    if (rst) begin
      m_armed = 0; m_report = 0; m_ready = 0; m_pass = 0;
      m_ed = 0; m_ek = 0; m_el = 0; m_fc = 0; m_fail = 0;
      m_exp = 0; m_lfsr = 8'hA5; m_seen = 0;
    end else if (m_report) begin
      m_report = 0;
    end else if (!m_armed) begin
      if (i_start && i_length != 0) begin
        m_armed    = 1;
        m_words    = (int'(i_length) + SW - 1) / SW;
        m_lastkeep = keep_for_len(int'(i_length));
        m_seen     = 0;
        m_ed = 0; m_ek = 0; m_el = 0; m_pass = 0;
        m_ready    = i_bp_en ? m_lfsr[0] : 1'b1;
      end
    end else begin
      acc     = i_valid && m_ready;
      m_lfsr  = lfsr_step(m_lfsr);
      m_ready = i_bp_en ? m_lfsr[0] : 1'b1;
      if (acc) begin
        m_seen = m_seen + 1;
        fin    = (m_seen == m_words);
        if (i_data != m_exp) m_ed = 1;
        if (fin && i_keep != m_lastkeep) m_ek = 1;
        if (!fin && i_keep != 4'hF) m_ek = 1;
        ended = fin || i_last;
        if (i_last && !fin) m_el = 1;
        if (fin && !i_last) m_el = 1;
        m_exp = i_data + 1;
        if (ended) begin
          m_armed = 0; m_report = 1; m_ready = 0;
          m_pass  = !(m_ed || m_ek || m_el);
          if (m_fc != 16'hFFFF) m_fc = m_fc + 1;
          if (!m_pass && m_fail != 16'hFFFF) m_fail = m_fail + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_ready", o_ready, m_ready);
      chk("cyc_busy", o_busy, m_armed);
      chk("cyc_done", o_done, m_report);
      chk("cyc_pass", o_pass, m_pass);
      chk("cyc_err_data", o_err_data, m_ed);
      chk("cyc_err_keep", o_err_keep, m_ek);
      chk("cyc_err_len", o_err_len, m_el);
      chk("cyc_frame_cnt", o_frame_cnt, m_fc);
      chk("cyc_fail_cnt", o_fail_cnt, m_fail);
    end
  end

  // Drives one frame like the generator: data follows gen_cnt, valid held until accepted.
  task automatic run_frame(input int len, input bit bp, input int bad_beat, input bit bad_keep,
                           input int early_last, input bit drop_last, input int stop_after,
                           input bit rnd);
    int words, nb, b, guard;
    logic [3:0] lk;
    bit acc;
    words = (len + SW - 1) / SW;
    lk    = keep_for_len(len);
    nb    = (early_last >= 0) ? early_last + 1 : words;
    if (stop_after >= 0) nb = stop_after;
    @(negedge clk);
    i_start = 1'b1; i_length = 10'(len); i_bp_en = bp;
    @(negedge clk);
    i_start = 1'b0;
    if (!bp) chk("ready_after_start", o_ready, 1);
    b = 0; guard = 0;
    while (b < nb && guard < 3000) begin
      i_start = rnd ? ($urandom_range(0, 40) == 0) : 1'b0;
      i_length = rnd ? 10'($urandom_range(0, 1023)) : i_length;
      i_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      i_data  = (b == bad_beat) ? 32'hDEAD : gen_cnt;
      i_keep  = (b == words - 1) ? lk : 4'hF;
      if (bad_keep && b == words - 1) i_keep = i_keep ^ 4'b0010;
      i_last  = (b == nb - 1) && !drop_last && (stop_after < 0);
      acc = i_valid && o_ready;
      @(negedge clk);
      if (acc) begin b++; gen_cnt++; end
      guard++;
    end
    if (b < nb) begin
      n_vec++; n_err++;
      $display("FAIL frame_timeout: accepted %0d beats, required %0d", b, nb);
    end
    i_valid = 1'b0; i_last = 1'b0; i_start = 1'b0;
  endtask

  task automatic expect_done(input string tag, input bit pass, input int fc, input int fl);
    chk({tag, "_done"}, o_done, 1);
    chk({tag, "_pass"}, o_pass, pass);
    chk({tag, "_frame_cnt"}, o_frame_cnt, fc);
    chk({tag, "_fail_cnt"}, o_fail_cnt, fl);
    chk({tag, "_busy"}, o_busy, 0);
  endtask

  task automatic reset_mid();
    #2 rst = 1'b1;
    #1;
    chk("rst_ready", o_ready, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_frame_cnt", o_frame_cnt, 0);
    chk("rst_fail_cnt", o_fail_cnt, 0);
    i_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_no_done", o_done, 0);
    end
    rst = 1'b0;
    gen_cnt = '0;
  endtask

  initial begin
    int len, words, bb, el;
    bit bk, dl;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    cmp_en = 1'b1;
    chk("lfsr_a5", lfsr_step(8'hA5), 32'h4A);
    chk("lfsr_4a", lfsr_step(8'h4A), 32'h95);
    chk("keep_13", keep_for_len(13), 32'h1);
    @(negedge clk);
    chk("reset_busy", o_busy, 0);
    chk("reset_ready", o_ready, 0);
    chk("reset_done", o_done, 0);
    chk("reset_frame_cnt", o_frame_cnt, 0);

    // Clean 13-byte frame: data 0..3, keep F,F,F,1.
    run_frame(13, 0, -1, 0, -1, 0, -1, 0);
    expect_done("t1", 1, 1, 0);
    @(negedge clk);
    chk("t1_done_pulse", o_done, 0);
    chk("t1_pass_held", o_pass, 1);

    // Back-to-back frames continue the data sequence.
    run_frame(8, 0, -1, 0, -1, 0, -1, 0);
    expect_done("t2a", 1, 2, 0);
    run_frame(4, 0, -1, 0, -1, 0, -1, 0);
    expect_done("t2b", 1, 3, 0);
    chk("t2_model_exp", m_exp, 7);

    // Backpressure from the seeded LFSR, then extra beats must not be accepted.
    @(negedge clk);
    reset_mid();
    run_frame(64, 1, -1, 0, -1, 0, -1, 0);
    expect_done("t3", 1, 1, 0);
    i_valid = 1'b1; i_data = gen_cnt; i_keep = 4'hF;
    repeat (3) begin
      @(negedge clk);
      chk("t3_no_extra", o_ready, 0);
    end
    i_valid = 1'b0;

    // Corrupted data on beat 2, then resync.
    run_frame(12, 0, 1, 0, -1, 0, -1, 0);
    expect_done("t4a", 0, 2, 1);
    chk("t4a_err_data", o_err_data, 1);
    run_frame(12, 0, -1, 0, -1, 0, -1, 0);
    expect_done("t4a_resync", 1, 3, 1);
    // Early last on beat 2.
    run_frame(12, 0, -1, 0, 1, 0, -1, 0);
    expect_done("t4b", 0, 4, 2);
    chk("t4b_err_len", o_err_len, 1);
    // Missing last on the counted final beat.
    run_frame(12, 0, -1, 0, -1, 1, -1, 0);
    expect_done("t4c", 0, 5, 3);
    chk("t4c_err_len", o_err_len, 1);

    // Last-beat keep 3 instead of 1.
    run_frame(13, 0, -1, 1, -1, 0, -1, 0);
    expect_done("t5", 0, 6, 4);
    chk("t5_err_keep", o_err_keep, 1);
    chk("t5_err_data", o_err_data, 0);

    // Zero-length start is ignored.
    @(negedge clk);
    i_start = 1'b1; i_length = 10'd0;
    @(negedge clk);
    i_start = 1'b0;
    chk("t6_len0_busy", o_busy, 0);
    @(negedge clk);
    chk("t6_len0_busy2", o_busy, 0);

    // Reset after beat 2 of 4.
    run_frame(16, 0, -1, 0, -1, 0, 2, 0);
    reset_mid();
    run_frame(13, 0, -1, 0, -1, 0, -1, 0);
    expect_done("t6_after_rst", 1, 1, 0);

    // Randomized frames with gaps, stray starts, idle garbage and occasional errors.
    for (int f = 0; f < 25; f++) begin
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        i_valid = 1'($urandom_range(0, 1));
        i_data = $urandom; i_keep = 4'($urandom); i_last = 1'($urandom_range(0, 1));
      end
      i_valid = 1'b0; i_last = 1'b0;
      len   = $urandom_range(1, 300);
      words = (len + SW - 1) / SW;
      bb    = ($urandom_range(0, 5) == 0) ? $urandom_range(0, words - 1) : -1;
      bk    = ($urandom_range(0, 7) == 0);
      el    = (words > 1 && $urandom_range(0, 7) == 0) ? $urandom_range(0, words - 2) : -1;
      dl    = (el < 0) && ($urandom_range(0, 7) == 0);
      run_frame(len, 1'($urandom_range(0, 1)), bb, bk, el, dl, -1, 1);
      chk("rand_done", o_done, 1);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axi_data_check.md
Name: axi_data_check

Overview:
- Stream sink that sits directly downstream of the AXI-stream test-data generator and consumes its data/valid/keep/last output.
- Drives ready back to the generator, with optional pseudo-random backpressure.
- Checks each frame for the incrementing data pattern, the keep mask and the frame length against the programmed byte length.
- Reports per-frame pass/fail plus sticky error flags and counters for the PS/ILA.

Parameters:
DATA_WIDTH, 32, stream data width in bits (power of two, 16..64)
STRB_WIDTH, DATA_WIDTH/8, keep width, bytes per beat
LFSR_SEED, 8'hA5, non-zero reset seed of the backpressure LFSR

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
i_start  in  1  arm check of one frame; single-cycle pulse
i_length  in  10  expected frame length in bytes, sampled with i_start
i_bp_en  in  1  1 = throttle o_ready with LFSR; 0 = ready held high while armed
i_data  in  DATA_WIDTH  stream data
i_valid  in  1  stream valid
i_keep  in  STRB_WIDTH  byte enables
i_last  in  1  end of frame
o_ready  out  1  stream ready
o_busy  out  1  frame armed / in progress
o_done  out  1  one-cycle pulse at frame completion
o_pass  out  1  frame result, valid with o_done, held until next i_start
o_err_data  out  1  sticky: data mismatch in current frame
o_err_keep  out  1  sticky: keep mismatch in current frame
o_err_len  out  1  sticky: i_last early or missing
o_frame_cnt  out  16  completed frames, saturating
o_fail_cnt  out  16  failed frames, saturating

Behaviour:
Reset (async assert, sync release):
- FSM in IDLE; all outputs 0.
- Expected-data register = 0; LFSR = LFSR_SEED.

Beat acceptance:
- A beat is accepted when i_valid & o_ready.
- o_ready is registered and never depends on i_valid in the same cycle, because the upstream valid is gated combinationally by ready.
- o_ready = 0 outside RUN.
- In RUN: o_ready = 1 if i_bp_en = 0, else LFSR bit 0.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4; advances every cycle in RUN.

Derived values:
- Words = ceil(i_length / STRB_WIDTH) = i_length[9:log2 STRB] + OR(i_length[log2 STRB - 1:0]).
- Last-beat keep: all ones if i_length mod STRB_WIDTH = 0, else low (i_length mod STRB_WIDTH) bits set.
- Non-last beats: keep must be all ones.

FSM states IDLE, RUN, DONE:
- IDLE -> RUN on i_start with i_length != 0. On that transition:
  - latch words and last-keep;
  - clear beat counter and the three sticky flags;
  - o_pass = 0; o_busy = 1.
- i_start with i_length = 0 is ignored; the FSM stays in IDLE.
- i_start in RUN or DONE is ignored.
- RUN, per accepted beat:
  - compare i_data with the expected register; mismatch sets o_err_data.
  - expected register <- i_data + 1 (resync, avoids cascaded errors).
  - compare i_keep against the expected mask for that beat position; mismatch sets o_err_keep.
  - beat counter increments.
- RUN -> DONE on an accepted beat that is the counted final beat or carries i_last:
  - i_last before the final beat sets o_err_len;
  - final beat without i_last sets o_err_len.
- DONE: held for 1 cycle.
  - o_done = 1; o_pass = NOR of the sticky flags, including an error flagged on the final beat.
  - o_frame_cnt +1; o_fail_cnt +1 if not pass; both saturate at 16'hFFFF.
  - o_ready = 0; next state IDLE; o_busy = 0.
- Latency: o_done is asserted exactly 1 cycle after the final accepted beat.

Cross-frame and idle rules:
- The expected-data register persists across frames and wraps modulo 2^DATA_WIDTH, matching the generator's free-running counter.
- A valid beat in IDLE is not accepted and not checked.
- rst mid-frame aborts the frame; no o_done; counters cleared.

Arithmetic and widths:
- Beat counter is 10 bits.
- Width of the words value is 10 - log2(STRB_WIDTH) + 1 bits.
- All compares are unsigned.

Test Plan:
1. Reset, i_start with i_length = 13, i_bp_en = 0, generator-correct stream:
   - data 0,1,2,3; keep F,F,F,1; i_last on beat 4;
   - -> o_ready high from the cycle after start, o_done 1 cycle after beat 4, o_pass = 1, o_frame_cnt = 1.
2. Back-to-back frames of length 8 then 4 (data continues 4,5 then 6):
   - -> both pass; o_frame_cnt = 3; expected register = 7.
3. i_bp_en = 1, length 64, seed A5:
   - -> o_ready toggles per LFSR; all 16 beats accepted only when ready; pass; no extra beats accepted after last.
4. Errors:
   - length 12, beat 2 data corrupted to 0xDEAD -> o_err_data = 1, o_pass = 0, o_fail_cnt +1; next frame passes (resync).
   - length 12, i_last on beat 2 -> o_err_len = 1, o_done after beat 2.
5. Keep check: length 13, last keep 3 instead of 1 -> o_err_keep = 1, fail.
6. Start-rule and reset corners:
   - i_start with length 0 -> stays IDLE, o_busy = 0.
   - rst asserted mid-frame (after beat 2 of 4) -> o_ready = 0 immediately, counters 0, no o_done.
